// File: rtl/wb_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator_pkg
// Purpose  : FSM state and response status types shared by wb_initiator.
// Revision : 1.0 - initial release
// ============================================================================
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t STATUS_OK      = 2'b00;
    localparam status_t STATUS_ERR     = 2'b01;
    localparam status_t STATUS_RTY     = 2'b10;
    localparam status_t STATUS_TIMEOUT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Purpose  : Single-outstanding Wishbone pipelined initiator; valid/ready
//            command in, valid/ready response out. Optional watchdog via
//            WB_INITIATOR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   cmd_sel_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_dat_o,
    output logic [1:0]                rsp_status_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDR_WIDTH-1:0]     wb_adr_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_rty_i,
    input  logic                      wb_stall_i
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_ready_en;
    logic                      r_we;
    logic [ADDR_WIDTH-1:0]     r_adr;
    logic [DATA_WIDTH-1:0]     r_dat;
    logic [DATA_WIDTH/8-1:0]   r_sel;
    logic [DATA_WIDTH-1:0]     r_rsp_dat;
    status_t                   r_rsp_status;

    logic                      w_accept;
    logic                      w_busy;
    logic                      w_live;
    logic                      w_term;
    logic                      w_timeout;
    logic [DATA_WIDTH-1:0]     w_rsp_dat;
    status_t                   w_rsp_status;

    assign w_accept = (r_state == ST_IDLE) && r_ready_en && cmd_valid_i;
    assign w_busy   = (r_state == ST_REQ) || (r_state == ST_WAIT);
    // A termination only counts once the slave has taken the request.
    assign w_live   = (r_state == ST_WAIT) || ((r_state == ST_REQ) && !wb_stall_i);
    assign w_term   = w_live && (wb_err_i || wb_rty_i || wb_ack_i);

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (w_busy) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_timeout = w_busy && (r_tmo_cnt == c_tmo_last) && !w_term;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_REQ;
            ST_REQ: begin
                if (w_term || w_timeout) w_state_next = ST_RSP;
                else if (!wb_stall_i)    w_state_next = ST_WAIT;
            end
            ST_WAIT: if (w_term || w_timeout) w_state_next = ST_RSP;
            ST_RSP:  if (rsp_ready_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Falls through to timeout status when no termination is present.
    always_comb begin
        w_rsp_dat    = '0;
        w_rsp_status = STATUS_TIMEOUT;
        if (wb_err_i) begin
            w_rsp_status = STATUS_ERR;
        end else if (wb_rty_i) begin
            w_rsp_status = STATUS_RTY;
        end else if (wb_ack_i) begin
            w_rsp_status = STATUS_OK;
            if (!r_we) w_rsp_dat = wb_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ready_en   <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_rsp_dat    <= '0;
            r_rsp_status <= STATUS_OK;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
                r_sel <= cmd_sel_i;
            end
            if (w_term || w_timeout) begin
                r_rsp_dat    <= w_rsp_dat;
                r_rsp_status <= w_rsp_status;
            end
        end
    end

    assign cmd_ready_o  = r_ready_en && (r_state == ST_IDLE);
    assign wb_cyc_o     = w_busy;
    assign wb_stb_o     = (r_state == ST_REQ);
    assign wb_we_o      = r_we;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign wb_sel_o     = r_sel;
    assign rsp_valid_o  = (r_state == ST_RSP);
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_rsp_status;

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_initiator
// Purpose  : Self-checking bench for wb_initiator; timeline model per
//            transaction plus literal pins. Honours WB_INITIATOR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;
    import wb_initiator_pkg::*;

    localparam int TMO = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i = '0;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;

    always #5 clk = ~clk;

    wb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
        .wb_rty_i(wb_rty), .wb_stall_i(wb_stall)
    );

    // Expected outputs for the current cycle, written by the driver only.
    logic        chk_en = 1'b0;
    logic        e_cmd_ready = 1'b0, e_cyc = 1'b0, e_stb = 1'b0, e_rsp_valid = 1'b0, e_we = 1'b0;
    logic [31:0] e_adr = '0, e_dat = '0, e_rdat = '0;
    logic [3:0]  e_sel = '0;
    logic [1:0]  e_status = STATUS_OK;

    // Literal checks handed from the driver to the compare process.
    string       lit_name = "";
    logic [31:0] lit_act = '0, lit_exp = '0;
    int          lit_seq = 0, lit_done = 0;

    int total = 0, bad = 0;
    int stb_cnt = 0, cyc_cnt = 0;
    logic [31:0] last_dat = '0;
    logic [1:0]  last_st = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wb_stb === 1'b1) stb_cnt++;
        if (wb_cyc === 1'b1) cyc_cnt++;
        if (lit_seq != lit_done) begin
            chk(lit_name, lit_act, lit_exp);
            lit_done = lit_seq;
        end
        if (chk_en) begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_cmd_ready});
            chk("wb_cyc", {31'd0, wb_cyc}, {31'd0, e_cyc});
            chk("wb_stb", {31'd0, wb_stb}, {31'd0, e_stb});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rsp_valid});
            if (e_cyc) begin
                chk("wb_we", {31'd0, wb_we}, {31'd0, e_we});
                chk("wb_adr", wb_adr, e_adr);
                chk("wb_dat", wb_dat_o, e_dat);
                chk("wb_sel", {28'd0, wb_sel}, {28'd0, e_sel});
            end
            if (e_rsp_valid) begin
                chk("rsp_dat", rsp_dat, e_rdat);
                chk("rsp_status", {30'd0, rsp_status}, {30'd0, e_status});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_name = n;
        lit_act  = a;
        lit_exp  = e;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic quiet_bus();
        {wb_ack, wb_err, wb_rty, wb_stall} = 4'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    // Called one time unit after a rising edge; asserts reset mid-cycle.
    task automatic async_reset_mid();
        logic c, s;
        #1 rst_n = 1'b0;
        #1;
        c = wb_cyc;
        s = wb_stb;
        chk_en = 1'b0;
        quiet_bus();
        post("rst_mid_cyc", {31'd0, c}, 32'd0);
        post("rst_mid_stb", {31'd0, s}, 32'd0);
        post("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        post("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        e_cmd_ready = 1'b1; e_cyc = 1'b0; e_stb = 1'b0; e_rsp_valid = 1'b0;
        chk_en = 1'b1;
    endtask

    // kind: 0 ack, 1 err, 2 rty, 3 err+ack(+rty), 4 silent, 5 rty+ack, 6 reset at termination slot
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int n_stall, input int n_wait,
                       input int kind, input int n_hold, input logic pend,
                       input logic [31:0] rdat);
        int t, t_term;
        logic term_now, tmo_now, fin, c1000;
        logic [1:0] st;
        logic [31:0] rd;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        e_cmd_ready = 1'b1; e_cyc = 1'b0; e_stb = 1'b0; e_rsp_valid = 1'b0;
        step();
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        e_we = we; e_adr = adr; e_dat = dat; e_sel = sel;
        e_cmd_ready = 1'b0; e_cyc = 1'b1;
        t_term = n_stall + 1 + n_wait;
        t = 0; fin = 1'b0; tmo_now = 1'b0;
        while (!fin) begin
            t++;
            if (kind == 6 && t == t_term) begin
                async_reset_mid();
                return;
            end
            e_stb    = (t <= n_stall + 1);
            wb_stall = (t <= n_stall) ? 1'b1 : ((t > n_stall + 1) ? 1'($urandom) : 1'b0);
            wb_dat_i = $urandom;
            term_now = (kind != 4) && (t == t_term);
            {wb_err, wb_rty, wb_ack} = 3'b000;
            if (term_now) begin
                wb_dat_i = rdat;
                case (kind)
                    0: wb_ack = 1'b1;
                    1: wb_err = 1'b1;
                    2: wb_rty = 1'b1;
                    3: begin wb_err = 1'b1; wb_ack = 1'b1; wb_rty = 1'($urandom); end
                    default: begin wb_rty = 1'b1; wb_ack = 1'b1; end
                endcase
            end else if (t <= n_stall) begin
                {wb_err, wb_rty, wb_ack} = 3'($urandom);
            end
            tmo_now = TMO_EN && (t == TMO) && !term_now;
            step();
            if (term_now || tmo_now) begin
                fin = 1'b1;
            end else if (!TMO_EN && t == 1000) begin
                c1000 = wb_cyc;
                async_reset_mid();
                post("cyc_after_1000", {31'd0, c1000}, 32'd1);
                return;
            end
        end
        if (tmo_now) begin
            st = STATUS_TIMEOUT; rd = '0;
        end else begin
            case (kind)
                0:       begin st = STATUS_OK;  rd = we ? 32'd0 : rdat; end
                1, 3:    begin st = STATUS_ERR; rd = '0; end
                default: begin st = STATUS_RTY; rd = '0; end
            endcase
        end
        e_cyc = 1'b0; e_stb = 1'b0; e_rsp_valid = 1'b1; e_status = st; e_rdat = rd;
        cmd_valid = pend;
        rsp_ready = 1'b0;
        for (int h = 0; h <= n_hold; h++) begin
            {wb_err, wb_rty, wb_ack, wb_stall} = 4'($urandom);
            wb_dat_i = $urandom;
            if (h == n_hold) begin
                rsp_ready = 1'b1;
                last_dat  = rsp_dat;
                last_st   = rsp_status;
            end
            step();
        end
        quiet_bus();
        e_rsp_valid = 1'b0; e_cmd_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int s0, c0, k;
        logic [31:0] ra;
        repeat (2) @(negedge clk);
        #1;
        post("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        post("rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        post("rst_wb_adr", wb_adr, 32'd0);
        post("rst_wb_dat", wb_dat_o, 32'd0);
        post("rst_wb_we_sel", {27'd0, wb_we, wb_sel}, 32'd0);
        post("rst_rsp", {rsp_dat[29:0], rsp_status}, 32'd0);
        post("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        e_cmd_ready = 1'b1;
        chk_en = 1'b1;
        post("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        s0 = stb_cnt;
        txn(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 1'b0, 32'h0);
        post("wr_stb_len", stb_cnt - s0, 32'd1);
        post("wr_rsp_dat", last_dat, 32'd0);
        post("wr_rsp_status", {30'd0, last_st}, 32'd0);
        @(posedge clk); #1;

        s0 = stb_cnt;
        txn(1'b0, 32'h4, 32'h0, 4'hF, 3, 1, 0, 0, 1'b0, 32'h00000712);
        post("rd_stb_len", stb_cnt - s0, 32'd4);
        post("rd_rsp_dat", last_dat, 32'h712);
        @(posedge clk); #1;

        c0 = cyc_cnt;
        txn(1'b0, 32'h8, 32'h0, 4'h3, 0, 1, 3, 1, 1'b0, 32'hA5A5A5A5);
        post("err_ack_status", {30'd0, last_st}, {30'd0, STATUS_ERR});
        post("err_ack_dat", last_dat, 32'd0);
        txn(1'b1, 32'hC, 32'h1234, 4'h1, 0, 0, 2, 0, 1'b0, 32'h0);
        post("rty_status", {30'd0, last_st}, {30'd0, STATUS_RTY});
        post("no_retry_cyc", cyc_cnt - c0, 32'd3);
        @(posedge clk); #1;

        txn(1'b0, 32'h10, 32'h0, 4'hF, 1, 2, 0, 5, 1'b1, 32'hCAFEF00D);
        txn(1'b1, 32'h14, 32'h55AA55AA, 4'hC, 0, 1, 0, 0, 1'b0, 32'h0);

        c0 = cyc_cnt;
        txn(1'b0, 32'h18, 32'h0, 4'hF, 0, 0, 4, 1, 1'b0, 32'h0);
        if (TMO_EN) begin
            post("tmo_cyc_len", cyc_cnt - c0, TMO);
            post("tmo_status", {30'd0, last_st}, {30'd0, STATUS_TIMEOUT});
        end
        @(posedge clk); #1;

        txn(1'b0, 32'h1C, 32'h0, 4'hF, 3, 4, 0, 0, 1'b0, 32'h0BADF00D);
        post("term_at_limit_status", {30'd0, last_st}, {30'd0, STATUS_OK});
        @(posedge clk); #1;

        txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 2, 6, 0, 1'b0, 32'h0);
        txn(1'b0, 32'h24, 32'h0, 4'hF, 1, 1, 0, 0, 1'b0, 32'h13579BDF);
        post("post_reset_rd", last_dat, 32'h13579BDF);
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    k = 0;
                2:       k = 1;
                3:       k = 2;
                4:       k = 3;
                default: k = 5;
            endcase
            ra = $urandom;
            txn(1'($urandom), {ra[31:2], 2'b00}, $urandom, 4'($urandom),
                $urandom_range(0, 4),
                ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 4),
                k, $urandom_range(0, 3), 1'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
